snake_body: RTL

SNAKE_BODY -- requirements
Module: snake_body

---
 rtl/snake_pkg.sv | 31 +++
 rtl/snake_seg_fifo.sv | 61 ++++++
 rtl/snake_body.sv | 125 ++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types, constants and helpers for the snake body
// Contents: GRID_W, dir_e heading enum, pos_t {y,x} cell, start-of-game
// constants and board_idx() mapping a cell to its occupancy-map bit.
package snake_pkg;

    localparam int GRID_W = 16;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_e;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } pos_t;

    // Starting body, tail to head: (5,7), (6,7), (7,7)
    localparam pos_t START_SEG0 = 8'h75;
    localparam pos_t START_SEG1 = 8'h76;
    localparam pos_t START_SEG2 = 8'h77;
    localparam logic [255:0] START_BOARD = 256'd7 << 117;

    // Bit y*16+x of the board is exactly the concatenation {y,x}
    function automatic logic [7:0] board_idx(input pos_t p);
        return {p.y, p.x};
    endfunction

endpackage

// File: rtl/snake_seg_fifo.sv
// rtl/snake_seg_fifo.sv - ring buffer of body segment positions
// Ports: clk, rst (sync, active-high; loads the three-segment start body),
//        push_i/push_data_i (new head), pop_i (drop tail),
//        head_o/tail_o (current head/tail cell), count_o (segments held).
// Push and pop in the same cycle are allowed even when full: the new head
// lands in the slot the departing tail vacates.
module snake_seg_fifo
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  pos_t       push_data_i,
    input  logic       pop_i,
    output pos_t       head_o,
    output pos_t       tail_o,
    output logic [5:0] count_o
);

    localparam int PW = $clog2(MAX_LEN);

    pos_t          mem_q [MAX_LEN];
    logic [PW-1:0] hd_q, hd_d;
    logic [PW-1:0] tl_q, tl_d;
    logic [5:0]    cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        hd_d  = push_i ? ptr_next(hd_q) : hd_q;
        tl_d  = pop_i  ? ptr_next(tl_q) : tl_q;
        cnt_d = cnt_q + 6'(push_i) - 6'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= START_SEG0;
            mem_q[1] <= START_SEG1;
            mem_q[2] <= START_SEG2;
            tl_q     <= '0;
            hd_q     <= PW'(2);
            cnt_q    <= 6'd3;
        end else begin
            if (push_i) begin
                mem_q[hd_d] <= push_data_i;
            end
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[hd_q];
    assign tail_o  = mem_q[tl_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/snake_body.sv
// rtl/snake_body.sv - snake body tracker: heading, movement, growth, collision
// Ports: clk, rst (sync, active-high), step (move strobe), dir (requested
//        heading), apple_x/apple_y (apple cell); outputs x/y (head), board
//        (256-bit occupancy map), length, alive, ate (one-cycle eat pulse).
// Build option: define SNAKE_WRAP_EN to wrap coordinates at the grid edges
// instead of treating an edge crossing as fatal.
module snake_body
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic [1:0]   dir,
    input  logic [3:0]   apple_x,
    input  logic [3:0]   apple_y,
    output logic [3:0]   x,
    output logic [3:0]   y,
    output logic [255:0] board,
    output logic [5:0]   length,
    output logic         alive,
    output logic         ate
);

    dir_e         heading_q;
    logic         alive_q;
    logic         ate_q;
    logic [255:0] board_q, board_d;

    dir_e         eff_dir;
    pos_t         head, tail, next_pos;
    logic         at_edge, off_grid;
    logic         apple_hit, grow, tail_vacates, fatal, do_move;
    logic [5:0]   count;

    snake_seg_fifo #(.MAX_LEN(MAX_LEN)) u_segs (
        .clk         (clk),
        .rst         (rst),
        .push_i      (do_move),
        .push_data_i (next_pos),
        .pop_i       (do_move && !grow),
        .head_o      (head),
        .tail_o      (tail),
        .count_o     (count)
    );

    always_comb begin
        // Opposite headings differ only in bit 1
        if (dir == (2'(heading_q) ^ 2'd2)) begin
            eff_dir = heading_q;
        end else begin
            eff_dir = dir_e'(dir);
        end

        next_pos = head;
        at_edge  = 1'b0;
        case (eff_dir)
            UP: begin
                next_pos.y = head.y - 4'd1;
                at_edge    = (head.y == 4'd0);
            end
            RIGHT: begin
                next_pos.x = head.x + 4'd1;
                at_edge    = (head.x == 4'(GRID_W - 1));
            end
            DOWN: begin
                next_pos.y = head.y + 4'd1;
                at_edge    = (head.y == 4'(GRID_W - 1));
            end
            default: begin
                next_pos.x = head.x - 4'd1;
                at_edge    = (head.x == 4'd0);
            end
        endcase

`ifdef SNAKE_WRAP_EN
        // 4-bit arithmetic above already wraps modulo 16
        off_grid = 1'b0;
`else
        off_grid = at_edge;
`endif

        apple_hit = (next_pos == {apple_y, apple_x});
        grow      = apple_hit && (count < 6'(MAX_LEN));
        // Moving into the tail is legal when the tail leaves this same cycle
        tail_vacates = !grow && (next_pos == tail);
        fatal   = off_grid || (board_q[board_idx(next_pos)] && !tail_vacates);
        do_move = step && alive_q && !fatal;

        board_d = board_q;
        if (!grow) begin
            board_d[board_idx(tail)] = 1'b0;
        end
        board_d[board_idx(next_pos)] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            heading_q <= RIGHT;
            alive_q   <= 1'b1;
            ate_q     <= 1'b0;
            board_q   <= START_BOARD;
        end else begin
            ate_q <= 1'b0;
            if (step && alive_q) begin
                if (fatal) begin
                    alive_q <= 1'b0;
                end else begin
                    heading_q <= eff_dir;
                    ate_q     <= apple_hit;
                    board_q   <= board_d;
                end
            end
        end
    end

    assign x      = head.x;
    assign y      = head.y;
    assign board  = board_q;
    assign length = count;
    assign alive  = alive_q;
    assign ate    = ate_q;

endmodule
